// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package riscv_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] RISCV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: core control, instruction-memory handshake and the IF/ID head.
interface instr_fetch_unit_if;
    import riscv_fetch_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;

    modport master (
        input  redirect_valid, redirect_pc, stall,
        input  imem_ready, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        output redirect_valid, redirect_pc, stall,
        output imem_ready, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  if_valid, if_pc, if_instr
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instructions; entries are allocated at issue and
// filled in allocation order as responses return.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [ILEN-1:0] fill_data_i,
    input  logic            pop_i,
    output logic [CW-1:0]   count_o,
    output logic [CW-1:0]   unfilled_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t [DEPTH-1:0] mem_q;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, nfill_q;
    logic [AW-1:0] fidx;

    // Filled entries are always a prefix starting at head, so the oldest
    // unfilled slot sits right after them.
    assign fidx = head_q + AW'(nfill_q);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            nfill_q <= '0;
        end else begin
            if (alloc_i) begin
                mem_q[tail_q] <= '{pc: alloc_pc_i, instr: RISCV_NOP, filled: 1'b0};
                tail_q        <= tail_q + AW'(1);
            end
            if (fill_i) begin
                mem_q[fidx].instr  <= fill_data_i;
                mem_q[fidx].filled <= 1'b1;
            end
            if (pop_i) head_q <= head_q + AW'(1);
            count_q <= count_q + CW'(alloc_i) - CW'(pop_i);
            nfill_q <= nfill_q + CW'(fill_i) - CW'(pop_i);
        end
    end

    // Slots are not cleared on flush; an empty queue must never report a filled head.
    always_comb begin
        head_o        = mem_q[head_q];
        head_o.filled = mem_q[head_q].filled && (count_q != '0);
    end

    assign count_o    = count_q;
    assign unfilled_o = count_q - nfill_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC sequencing, in-order imem handshake, stale
// response discard after redirect, and the buffered head toward IF/ID.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset,
    instr_fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count, unfilled;
    logic [CW:0]     occ;
    fetch_entry_t    head;
    logic            accept, rsp_drop, rsp_fill, fill, if_valid, pop;

    assign occ          = {1'b0, count} + {1'b0, drop_q};
    assign bus.imem_req = !reset && !bus.redirect_valid && (occ < (CW+1)'(DEPTH));
    assign bus.imem_addr = fpc_q;
    assign accept       = bus.imem_req && bus.imem_ready;

    assign rsp_drop = bus.imem_rvalid && (drop_q != '0);
    assign rsp_fill = bus.imem_rvalid && (drop_q == '0) && (unfilled != '0);
    assign fill     = rsp_fill && !bus.redirect_valid;

    assign if_valid = head.filled && !bus.redirect_valid;
    assign pop      = if_valid && !bus.stall;

    always_comb begin
        fpc_d  = fpc_q;
        drop_d = drop_q;
        if (bus.redirect_valid) begin
            // Every unfilled entry becomes a stale response, less one landing now.
            drop_d = drop_q - CW'(rsp_drop) + unfilled - CW'(rsp_fill);
            fpc_d  = bus.redirect_pc & ~XLEN'(3);
        end else begin
            if (accept)   fpc_d  = fpc_q + XLEN'(4);
            if (rsp_drop) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q  <= RESET_PC;
            drop_q <= '0;
        end else begin
            fpc_q  <= fpc_d;
            drop_q <= drop_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush_i    (bus.redirect_valid),
        .alloc_i    (accept),
        .alloc_pc_i (fpc_q),
        .fill_i     (fill),
        .fill_data_i(bus.imem_rdata),
        .pop_i      (pop),
        .count_o    (count),
        .unfilled_o (unfilled),
        .head_o     (head)
    );

    assign bus.if_valid = if_valid;
    assign bus.if_pc    = if_valid ? head.pc : '0;
    assign bus.if_instr = if_valid ? head.instr : RISCV_NOP;

    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (reset)
        bus.imem_rvalid |-> (drop_q != '0 || unfilled != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order variable-latency imem model.
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] idata(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          ep;
    } req_t;

    req_t        mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          buf_n = 0;
    int          max_occ = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    bit          ready_tog = 1'b0;
    logic [63:0] exp_pc = 64'h0;

    // Memory response side: drive the cycle's ready/rvalid just after the edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        bus.imem_ready = ready_tog ? cyc[0] : 1'b1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = idata(mq[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    // Memory bookkeeping plus in-order stream scoreboard, mid-cycle.
    always @(negedge clk) begin
        req_t r;
        if (reset) begin
            mq.delete();
            buf_n  = 0;
            exp_pc = 64'h0;
        end else begin
            if (bus.imem_rvalid && mq.size() > 0) begin
                if (mq[0].ep == epoch && !bus.redirect_valid) buf_n++;
                void'(mq.pop_front());
            end
            if (bus.if_valid && !bus.stall && !bus.redirect_valid) begin
                chk("if_pc", bus.if_pc, exp_pc);
                chk("if_instr", {32'h0, bus.if_instr}, {32'h0, idata(exp_pc)});
                exp_pc += 64'd4;
                buf_n--;
                n_pop++;
            end
            if (!bus.if_valid) chk("nop_when_invalid", {32'h0, bus.if_instr}, {32'h0, RISCV_NOP});
            if (bus.redirect_valid) begin
                chk("redir_if_valid", {63'h0, bus.if_valid}, 64'h0);
                chk("redir_imem_req", {63'h0, bus.imem_req}, 64'h0);
                buf_n  = 0;
                epoch++;
                exp_pc = bus.redirect_pc & ~64'h3;
            end
            if (bus.imem_req && bus.imem_ready) begin
                r.addr = bus.imem_addr;
                r.due  = cyc + lat;
                r.ep   = epoch;
                mq.push_back(r);
                n_acc++;
            end
            if (mq.size() + buf_n > max_occ) max_occ = mq.size() + buf_n;
        end
    end

    task automatic step(input bit rst, input bit rd, input logic [63:0] rp, input bit st);
        @(posedge clk);
        #1;
        reset              = rst;
        bus.redirect_valid = rd;
        bus.redirect_pc    = rp;
        bus.stall          = st;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int lim);
        for (int k = 0; k < lim && !bus.if_valid; k++) step(1'b0, 1'b0, 64'h0, 1'b0);
        chk(tag, {63'h0, bus.if_valid}, 64'h1);
    endtask

    initial begin
        int a0, p0;
        logic [63:0] hold_pc;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.stall          = 1'b0;
        bus.imem_ready     = 1'b1;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;

        // reset state
        step(1'b1, 1'b0, 64'h0, 1'b0);
        chk("rst_imem_req", {63'h0, bus.imem_req}, 64'h0);
        chk("rst_if_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("rst_if_pc", bus.if_pc, 64'h0);
        chk("rst_if_instr", {32'h0, bus.if_instr}, {32'h0, RISCV_NOP});

        // 1-cycle memory stream: first instruction visible in cycle 2
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("c0_imem_req", {63'h0, bus.imem_req}, 64'h1);
        chk("c0_imem_addr", bus.imem_addr, 64'h0);
        chk("c0_if_valid", {63'h0, bus.if_valid}, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("c1_imem_addr", bus.imem_addr, 64'h4);
        chk("c1_if_valid", {63'h0, bus.if_valid}, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("c2_imem_addr", bus.imem_addr, 64'h8);
        chk("c2_if_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("c2_if_pc", bus.if_pc, 64'h0);
        repeat (8) step(1'b0, 1'b0, 64'h0, 1'b0);

        // stall: head holds, issue stops at FULL
        a0 = n_acc;
        step(1'b0, 1'b0, 64'h0, 1'b1);
        hold_pc = exp_pc;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 64'h0, 1'b1);
            chk("stall_if_pc", bus.if_pc, hold_pc);
        end
        chk("stall_full_req", {63'h0, bus.imem_req}, 64'h0);
        chk("stall_acc_le_depth", {63'h0, (n_acc - a0) <= DEPTH}, 64'h1);
        repeat (10) step(1'b0, 1'b0, 64'h0, 1'b0);

        // latency 3 with toggling ready
        lat = 3;
        ready_tog = 1'b1;
        p0 = n_pop;
        repeat (30) step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("lat3_progress", {63'h0, (n_pop - p0) >= 5}, 64'h1);
        ready_tog = 1'b0;

        // three outstanding requests, then redirect to 0x100
        lat = 4;
        step(1'b1, 1'b0, 64'h0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h100, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("redir_addr", bus.imem_addr, 64'h100);
        chk("redir_req_after", {63'h0, bus.imem_req}, 64'h1);
        wait_valid("redir_wait", 20);
        chk("redir_first_pc", bus.if_pc, 64'h100);
        chk("redir_first_instr", {32'h0, bus.if_instr}, {32'h0, idata(64'h100)});

        // misaligned redirect target
        lat = 1;
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h103, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("align_addr", bus.imem_addr, 64'h100);
        wait_valid("align_wait", 20);
        chk("align_pc", bus.if_pc, 64'h100);

        // redirect coinciding with rvalid and a would-be pop
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h2000, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("coinc_req", {63'h0, bus.imem_req}, 64'h1);
        chk("coinc_addr", bus.imem_addr, 64'h2000);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("coinc_r2_valid", {63'h0, bus.if_valid}, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("coinc_r3_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("coinc_r3_pc", bus.if_pc, 64'h2000);

        // back-to-back redirects
        lat = 3;
        repeat (5) step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b1, 64'h300, 1'b0);
        step(1'b0, 1'b1, 64'h400, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("b2b_addr", bus.imem_addr, 64'h400);
        wait_valid("b2b_wait", 30);
        chk("b2b_pc", bus.if_pc, 64'h400);

        // reset with a full queue
        lat = 1;
        repeat (6) step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("full_req", {63'h0, bus.imem_req}, 64'h0);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        chk("rst_mid_req", {63'h0, bus.imem_req}, 64'h0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("rst_mid_valid", {63'h0, bus.if_valid}, 64'h0);
        chk("rst_mid_instr", {32'h0, bus.if_instr}, {32'h0, RISCV_NOP});
        chk("rst_mid_addr", bus.imem_addr, 64'h0);
        wait_valid("rst_mid_wait", 10);
        chk("rst_mid_pc", bus.if_pc, 64'h0);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b0);

        chk("max_occupancy", {63'h0, max_occ <= DEPTH}, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
